// File: rtl/rob_if.sv
// ============================================================================
// Module : rob_if
// Brief  : Allocation / writeback / commit bundle for rob_param.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rob_if #(
   parameter int DEPTH_LOG = 4,
   parameter int WB_PORTS  = 2,
   parameter int XLEN      = 32,
   parameter int RD_W      = 5
);
   logic                          rdy;
   logic                          alloc_valid;
   logic [XLEN-1:0]               alloc_pc;
   logic [RD_W-1:0]               alloc_rd;
   logic                          alloc_ready;
   logic [DEPTH_LOG-1:0]          alloc_tag;
   logic [WB_PORTS-1:0]           wb_valid;
   logic [WB_PORTS*DEPTH_LOG-1:0] wb_tag;
   logic [WB_PORTS*XLEN-1:0]      wb_data;
   logic [WB_PORTS-1:0]           wb_has_jpc;
   logic [WB_PORTS*XLEN-1:0]      wb_jpc;
   logic                          commit_valid;
   logic [XLEN-1:0]               commit_pc;
   logic [RD_W-1:0]               commit_rd;
   logic [XLEN-1:0]               commit_data;
   logic                          flush;
   logic [XLEN-1:0]               flush_pc;
   logic [DEPTH_LOG:0]            occupancy;
   logic                          wb_err;

   modport slave (
      input  rdy, alloc_valid, alloc_pc, alloc_rd,
      input  wb_valid, wb_tag, wb_data, wb_has_jpc, wb_jpc,
      output alloc_ready, alloc_tag,
      output commit_valid, commit_pc, commit_rd, commit_data,
      output flush, flush_pc, occupancy, wb_err
   );

   modport master (
      output rdy, alloc_valid, alloc_pc, alloc_rd,
      output wb_valid, wb_tag, wb_data, wb_has_jpc, wb_jpc,
      input  alloc_ready, alloc_tag,
      input  commit_valid, commit_pc, commit_rd, commit_data,
      input  flush, flush_pc, occupancy, wb_err
   );
endinterface

`default_nettype wire

// File: rtl/rob_param.sv
// ============================================================================
// Module : rob_param
// Brief  : Parameterised reorder buffer, in-order retire, mispredict flush.
//          Optional illegal-writeback sticky flag under `ROB_WB_ERR_EN`.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rob_param #(
   parameter int DEPTH_LOG = 4,
   parameter int WB_PORTS  = 2,
   parameter int XLEN      = 32,
   parameter int RD_W      = 5
) (
   input  wire logic clk,
   input  wire logic rst,
   rob_if.slave      bus
);
   localparam int DEPTH = 1 << DEPTH_LOG;
   localparam int PW    = DEPTH_LOG + 1;

   logic [XLEN-1:0]      r_pc   [DEPTH];
   logic [XLEN-1:0]      r_jpc  [DEPTH];
   logic [XLEN-1:0]      r_data [DEPTH];
   logic [RD_W-1:0]      r_rd   [DEPTH];
   logic [DEPTH-1:0]     r_done;
   logic [PW-1:0]        r_head;
   logic [PW-1:0]        r_tail;

   logic                 r_commit_valid;
   logic [XLEN-1:0]      r_commit_pc;
   logic [RD_W-1:0]      r_commit_rd;
   logic [XLEN-1:0]      r_commit_data;
   logic                 r_flush;
   logic [XLEN-1:0]      r_flush_pc;

   logic [DEPTH_LOG-1:0] w_head_idx;
   logic [DEPTH_LOG-1:0] w_tail_idx;
   logic                 w_empty;
   logic                 w_full;
   logic [PW-1:0]        w_occ;
   logic                 w_alloc;
   logic                 w_commit;
   logic                 w_flush;

   logic [DEPTH_LOG-1:0] w_wb_tag  [WB_PORTS];
   logic [XLEN-1:0]      w_wb_data [WB_PORTS];
   logic [XLEN-1:0]      w_wb_jpc  [WB_PORTS];
   logic [WB_PORTS-1:0]  w_wb_legal;
   logic [WB_PORTS-1:0]  w_wb_win;

   assign w_head_idx = r_head[DEPTH_LOG-1:0];
   assign w_tail_idx = r_tail[DEPTH_LOG-1:0];
   assign w_empty    = (r_head == r_tail);
   assign w_full     = (w_head_idx == w_tail_idx) && (r_head[DEPTH_LOG] != r_tail[DEPTH_LOG]);
   assign w_occ      = r_tail - r_head;
   assign w_alloc    = bus.alloc_valid && !w_full;
   assign w_commit   = !w_empty && r_done[w_head_idx];
   assign w_flush    = w_commit && (r_jpc[w_head_idx] != (r_pc[w_head_idx] + XLEN'(4)));

   // A tag is live when its distance from head is below the occupancy.
   generate
      for (genvar p = 0; p < WB_PORTS; p++) begin : g_port
         logic [DEPTH_LOG-1:0] w_off;
         assign w_wb_tag[p]   = bus.wb_tag[p*DEPTH_LOG +: DEPTH_LOG];
         assign w_wb_data[p]  = bus.wb_data[p*XLEN +: XLEN];
         assign w_wb_jpc[p]   = bus.wb_jpc[p*XLEN +: XLEN];
         assign w_off         = w_wb_tag[p] - w_head_idx;
         assign w_wb_legal[p] = bus.wb_valid[p] && ({1'b0, w_off} < w_occ)
                                && !r_done[w_wb_tag[p]];
      end
   endgenerate

   always_comb begin
      w_wb_win = w_wb_legal;
      for (int p = 0; p < WB_PORTS; p++) begin
         for (int q = 0; q < WB_PORTS; q++) begin
            if ((q < p) && w_wb_legal[q] && (w_wb_tag[q] == w_wb_tag[p])) begin
               w_wb_win[p] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_head         <= '0;
         r_tail         <= '0;
         r_done         <= '0;
         r_commit_valid <= 1'b0;
         r_commit_pc    <= '0;
         r_commit_rd    <= '0;
         r_commit_data  <= '0;
         r_flush        <= 1'b0;
         r_flush_pc     <= '0;
      end else if (!bus.rdy) begin
         r_commit_valid <= 1'b0;
         r_flush        <= 1'b0;
      end else begin
         r_commit_valid <= w_commit;
         r_flush        <= w_flush;
         if (w_commit) begin
            r_commit_pc   <= r_pc[w_head_idx];
            r_commit_rd   <= r_rd[w_head_idx];
            r_commit_data <= r_data[w_head_idx];
         end
         if (w_flush) begin
            r_flush_pc <= r_jpc[w_head_idx];
            r_head     <= '0;
            r_tail     <= '0;
            r_done     <= '0;
         end else begin
            if (w_commit) begin
               r_head <= r_head + PW'(1);
            end
            if (w_alloc) begin
               r_pc[w_tail_idx]   <= bus.alloc_pc;
               r_rd[w_tail_idx]   <= bus.alloc_rd;
               r_jpc[w_tail_idx]  <= bus.alloc_pc + XLEN'(4);
               r_done[w_tail_idx] <= 1'b0;
               r_tail             <= r_tail + PW'(1);
            end
            // The tail slot is never live, so alloc and writeback never collide.
            for (int p = 0; p < WB_PORTS; p++) begin
               if (w_wb_win[p]) begin
                  r_done[w_wb_tag[p]] <= 1'b1;
                  r_data[w_wb_tag[p]] <= w_wb_data[p];
                  if (bus.wb_has_jpc[p]) begin
                     r_jpc[w_wb_tag[p]] <= w_wb_jpc[p];
                  end
               end
            end
         end
      end
   end

`ifdef ROB_WB_ERR_EN
   logic                r_wb_err;
   logic [WB_PORTS-1:0] w_wb_bad;

   assign w_wb_bad = bus.wb_valid & ~w_wb_legal;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wb_err <= 1'b0;
      end else if (bus.rdy && (|w_wb_bad)) begin
         r_wb_err <= 1'b1;
      end
   end

   assign bus.wb_err = r_wb_err;
`else
   assign bus.wb_err = 1'b0;
`endif

   assign bus.alloc_ready  = !w_full;
   assign bus.alloc_tag    = w_tail_idx;
   assign bus.commit_valid = r_commit_valid;
   assign bus.commit_pc    = r_commit_pc;
   assign bus.commit_rd    = r_commit_rd;
   assign bus.commit_data  = r_commit_data;
   assign bus.flush        = r_flush;
   assign bus.flush_pc     = r_flush_pc;
   assign bus.occupancy    = w_occ;

endmodule

`default_nettype wire

// File: tb/tb_rob_param.sv
// ============================================================================
// Module : tb_rob_param
// Brief  : Directed self-checking bench for rob_param (default parameters).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rob_param;
   localparam int DL   = 4;
   localparam int WBP  = 2;
   localparam int XLEN = 32;
   localparam int RDW  = 5;
`ifdef ROB_WB_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   rob_if #(.DEPTH_LOG(DL), .WB_PORTS(WBP), .XLEN(XLEN), .RD_W(RDW)) bus ();

   rob_param #(.DEPTH_LOG(DL), .WB_PORTS(WBP), .XLEN(XLEN), .RD_W(RDW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.rdy         = 1'b1;
      bus.alloc_valid = 1'b0;
      bus.alloc_pc    = '0;
      bus.alloc_rd    = '0;
      bus.wb_valid    = '0;
      bus.wb_tag      = '0;
      bus.wb_data     = '0;
      bus.wb_has_jpc  = '0;
      bus.wb_jpc      = '0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   task automatic alloc(input logic [31:0] pc, input logic [4:0] rd);
      bus.alloc_valid = 1'b1;
      bus.alloc_pc    = pc;
      bus.alloc_rd    = rd;
   endtask

   task automatic drive_wb(input logic [1:0] v, input logic [3:0] t0, input logic [3:0] t1,
                           input logic [31:0] d0, input logic [31:0] d1);
      bus.wb_valid   = v;
      bus.wb_tag     = {t1, t0};
      bus.wb_data    = {d1, d0};
      bus.wb_has_jpc = '0;
   endtask

   initial begin
      int a;
      int exp_c;
      bit stall;

      // Reset state
      do_reset();
      check("rst_occ",    64'(bus.occupancy),    64'd0);
      check("rst_ready",  64'(bus.alloc_ready),  64'd1);
      check("rst_tag",    64'(bus.alloc_tag),    64'd0);
      check("rst_cvalid", 64'(bus.commit_valid), 64'd0);
      check("rst_cpc",    64'(bus.commit_pc),    64'd0);
      check("rst_flush",  64'(bus.flush),        64'd0);
      check("rst_fpc",    64'(bus.flush_pc),     64'd0);
      check("rst_err",    64'(bus.wb_err),       64'd0);

      // Fill to capacity, 17th request dropped
      for (int i = 0; i < 16; i++) begin
         alloc(32'h1000 + 32'(4 * i), 5'(i));
         check("fill_tag", 64'(bus.alloc_tag), 64'(i));
         step();
      end
      check("full_ready", 64'(bus.alloc_ready), 64'd0);
      check("full_occ",   64'(bus.occupancy),   64'd16);
      alloc(32'h1040, 5'd16);
      step();
      check("drop_occ",   64'(bus.occupancy),   64'd16);
      check("drop_tag",   64'(bus.alloc_tag),   64'd0);
      check("drop_ready", 64'(bus.alloc_ready), 64'd0);
      idle();

      // Reset wins over a stalled alloc request
      rst = 1'b0;
      bus.rdy = 1'b0;
      alloc(32'h9000, 5'd1);
      step();
      check("rstpri_occ",   64'(bus.occupancy),   64'd0);
      check("rstpri_ready", 64'(bus.alloc_ready), 64'd1);
      do_reset();

      // Out-of-order writeback, in-order commit
      for (int i = 0; i < 3; i++) begin
         alloc(32'h100 + 32'(4 * i), 5'(i + 1));
         step();
      end
      idle();
      drive_wb(2'b01, 4'd2, 4'd0, 32'h22, 32'h0);
      step();
      check("ooo_c0", 64'(bus.commit_valid), 64'd0);
      drive_wb(2'b01, 4'd0, 4'd0, 32'h20, 32'h0);
      step();
      check("ooo_c1", 64'(bus.commit_valid), 64'd0);
      drive_wb(2'b01, 4'd1, 4'd0, 32'h21, 32'h0);
      step();
      idle();
      check("ooo_v0",  64'(bus.commit_valid), 64'd1);
      check("ooo_pc0", 64'(bus.commit_pc),    64'h100);
      check("ooo_rd0", 64'(bus.commit_rd),    64'd1);
      check("ooo_d0",  64'(bus.commit_data),  64'h20);
      step();
      check("ooo_v1",  64'(bus.commit_valid), 64'd1);
      check("ooo_pc1", 64'(bus.commit_pc),    64'h104);
      check("ooo_d1",  64'(bus.commit_data),  64'h21);
      step();
      check("ooo_v2",  64'(bus.commit_valid), 64'd1);
      check("ooo_pc2", 64'(bus.commit_pc),    64'h108);
      check("ooo_d2",  64'(bus.commit_data),  64'h22);
      step();
      check("ooo_v3",   64'(bus.commit_valid), 64'd0);
      check("ooo_hold", 64'(bus.commit_pc),    64'h108);
      check("ooo_occ",  64'(bus.occupancy),    64'd0);

      // Mispredict flush
      do_reset();
      alloc(32'h2000, 5'd7);
      step();
      alloc(32'h2004, 5'd8);
      step();
      idle();
      drive_wb(2'b01, 4'd0, 4'd0, 32'h55, 32'h0);
      bus.wb_has_jpc = 2'b01;
      bus.wb_jpc     = {32'h0, 32'h2040};
      step();
      idle();
      alloc(32'h3000, 5'd9);
      check("fl_pre", 64'(bus.flush), 64'd0);
      step();
      idle();
      check("fl_cvalid", 64'(bus.commit_valid), 64'd1);
      check("fl_flush",  64'(bus.flush),        64'd1);
      check("fl_fpc",    64'(bus.flush_pc),     64'h2040);
      check("fl_cpc",    64'(bus.commit_pc),    64'h2000);
      check("fl_cdata",  64'(bus.commit_data),  64'h55);
      check("fl_occ",    64'(bus.occupancy),    64'd0);
      check("fl_tag",    64'(bus.alloc_tag),    64'd0);
      step();
      check("fl_once", 64'(bus.flush),        64'd0);
      check("fl_nocv", 64'(bus.commit_valid), 64'd0);
      check("fl_occ2", 64'(bus.occupancy),    64'd0);

      // Same-tag collision: lowest port wins
      do_reset();
      for (int i = 0; i < 4; i++) begin
         alloc(32'h400 + 32'(4 * i), 5'(i));
         step();
      end
      idle();
      drive_wb(2'b11, 4'd3, 4'd3, 32'hAA, 32'hBB);
      step();
      drive_wb(2'b11, 4'd0, 4'd1, 32'h10, 32'h11);
      step();
      drive_wb(2'b11, 4'd2, 4'd3, 32'h12, 32'hCC);
      step();
      idle();
      check("col_d0",  64'(bus.commit_data), 64'h10);
      check("col_err", 64'(bus.wb_err),      64'(ERR_EN));
      step();
      check("col_d1",  64'(bus.commit_data), 64'h11);
      step();
      check("col_d2",  64'(bus.commit_data), 64'h12);
      step();
      check("col_v3",  64'(bus.commit_valid), 64'd1);
      check("col_pc3", 64'(bus.commit_pc),    64'h40C);
      check("col_d3",  64'(bus.commit_data),  64'hAA);

      // Streaming alloc+commit with pointer wrap and a mid-stream stall
      do_reset();
      a = 0;
      exp_c = 0;
      for (int cyc = 0; cyc < 44; cyc++) begin
         stall = (cyc == 20) || (cyc == 21);
         idle();
         bus.rdy = !stall;
         alloc(32'h5000 + 32'(4 * a), 5'(a));
         if (a > 0) begin
            drive_wb(2'b01, 4'(a - 1), 4'd0, 32'hD000 + 32'(a - 1), 32'h0);
         end
         check("str_tag", 64'(bus.alloc_tag), 64'(a % 16));
         step();
         if (stall) begin
            check("str_stall_cv",  64'(bus.commit_valid), 64'd0);
            check("str_stall_occ", 64'(bus.occupancy),    64'd2);
         end else begin
            a++;
            if (a >= 3) begin
               check("str_cv",  64'(bus.commit_valid), 64'd1);
               check("str_pc",  64'(bus.commit_pc),    64'h5000 + 64'(4 * exp_c));
               check("str_d",   64'(bus.commit_data),  64'hD000 + 64'(exp_c));
               check("str_occ", 64'(bus.occupancy),    64'd2);
               exp_c++;
            end
         end
      end
      idle();

      // Writeback to an empty slot
      do_reset();
      drive_wb(2'b01, 4'd5, 4'd0, 32'h77, 32'h0);
      step();
      idle();
      check("err_set",  64'(bus.wb_err),    64'(ERR_EN));
      check("err_occ",  64'(bus.occupancy), 64'd0);
      step();
      step();
      check("err_hold", 64'(bus.wb_err),    64'(ERR_EN));
      do_reset();
      check("err_clr",  64'(bus.wb_err),    64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
